// File: rtl/sd_block_reader.sv
// sd_block_reader: SPI-mode CMD17 single-block read sequencer driving a byte-exchange engine.
// Define SD_BLOCK_READER_CRC_CHECK_EN to verify the CRC16 of the data block.
module sd_block_reader #(
  parameter int R1_TRIES = 8,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int BLOCK_ADDR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_lba,
  output logic        xfer_start,
  output logic [7:0]  xfer_tx,
  input  logic        xfer_done,
  input  logic [7:0]  xfer_rx,
  output logic        cs_n,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic [8:0]  rd_index,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code
);
  typedef enum logic [2:0] {IDLE, CMD, R1, TOKEN, DATA, CRC, TAIL, FIN} state_t;
  localparam logic [12:0] R1_LAST = 13'(R1_TRIES - 1);
  localparam logic [12:0] TOK_LAST = 13'(TOKEN_TIMEOUT - 1);
  state_t state;
  logic pend, failed, rx_ok, crc_bad;
  logic [12:0] pcnt, pcnt_inc;
  logic [9:0] dcnt, dcnt_inc;
  logic [39:0] cmd_sr;
  logic [2:0] fail_code;
  assign rx_ok = pend && xfer_done;
  assign pcnt_inc = &pcnt ? pcnt : pcnt + 13'd1;
  assign dcnt_inc = &dcnt ? dcnt : dcnt + 10'd1;
`ifdef SD_BLOCK_READER_CRC_CHECK_EN
  logic [15:0] crc;
  logic [7:0] crc_hi;
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
  assign crc_bad = state == CRC && dcnt != 10'd0 && {crc_hi, xfer_rx} != crc;
`else
  assign crc_bad = 1'b0;
`endif
  // Only meaningful while rx_ok; bytes other than 0xFE/0000xxxx in TOKEN count as idle polls.
  always_comb
    fail_code = crc_bad ? 3'd5 :
      state == R1 ? (!xfer_rx[7] ? (xfer_rx != 8'h00 ? 3'd2 : 3'd0) : (pcnt == R1_LAST ? 3'd1 : 3'd0)) :
      state == TOKEN && xfer_rx != 8'hFE ? (xfer_rx[7:4] == 4'h0 ? 3'd4 : (pcnt == TOK_LAST ? 3'd3 : 3'd0)) :
      3'd0;
  always_ff @(posedge clk) begin
    xfer_start <= 1'b0;
    rd_valid <= 1'b0;
    done <= 1'b0;
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      cs_n <= 1'b1;
      xfer_tx <= 8'hFF;
      pend <= 1'b0;
      failed <= 1'b0;
      pcnt <= '0;
      dcnt <= '0;
      cmd_sr <= '0;
      rd_data <= '0;
      rd_index <= '0;
      error <= 1'b0;
      err_code <= '0;
`ifdef SD_BLOCK_READER_CRC_CHECK_EN
      crc <= '0;
      crc_hi <= '0;
`endif
    end else if (state == IDLE) begin
      if (req_valid) begin
        state <= CMD;
        req_ready <= 1'b0;
        cs_n <= 1'b0;
        xfer_start <= 1'b1;
        xfer_tx <= 8'h51;
        pend <= 1'b1;
        cmd_sr <= {BLOCK_ADDR != 0 ? req_lba : {req_lba[22:0], 9'b0}, 8'hFF};
        pcnt <= '0;
        dcnt <= '0;
        failed <= 1'b0;
        error <= 1'b0;
        err_code <= '0;
`ifdef SD_BLOCK_READER_CRC_CHECK_EN
        crc <= '0;
`endif
      end
    end else if (state == FIN) begin
      state <= IDLE;
      req_ready <= 1'b1;
    end else if (rx_ok) begin
      pend <= 1'b1;
      xfer_start <= 1'b1;
      xfer_tx <= 8'hFF;
      if (fail_code != 3'd0) begin
        state <= TAIL;
        cs_n <= 1'b1;
        failed <= 1'b1;
        err_code <= fail_code;
      end else case (state)
        CMD: if (dcnt == 10'd5) begin
          state <= R1;
          pcnt <= '0;
        end else begin
          dcnt <= dcnt_inc;
          xfer_tx <= cmd_sr[39:32];
          cmd_sr <= {cmd_sr[31:0], 8'h00};
        end
        R1: if (!xfer_rx[7]) begin
          state <= TOKEN;
          pcnt <= '0;
        end else pcnt <= pcnt_inc;
        TOKEN: if (xfer_rx == 8'hFE) begin
          state <= DATA;
          dcnt <= '0;
        end else pcnt <= pcnt_inc;
        DATA: begin
          rd_valid <= 1'b1;
          rd_data <= xfer_rx;
          rd_index <= dcnt[8:0];
`ifdef SD_BLOCK_READER_CRC_CHECK_EN
          crc <= crc_next(crc, xfer_rx);
`endif
          state <= dcnt == 10'd511 ? CRC : DATA;
          dcnt <= dcnt == 10'd511 ? 10'd0 : dcnt_inc;
        end
        CRC: begin
`ifdef SD_BLOCK_READER_CRC_CHECK_EN
          crc_hi <= xfer_rx;
`endif
          dcnt <= dcnt_inc;
          if (dcnt != 10'd0) begin
            state <= TAIL;
            cs_n <= 1'b1;
          end
        end
        TAIL: begin
          xfer_start <= 1'b0;
          pend <= 1'b0;
          done <= 1'b1;
          error <= failed;
          state <= FIN;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sd_block_reader.md
# sd_block_reader

Sequencer for single-block SD card reads in SPI mode. It takes a block-read request from the SoC side and drives a byte-exchange SPI engine through the CMD17 transaction: command, R1 response, data token, 512 data bytes and CRC. It streams data bytes to a sink and reports completion or a coded error. It sits between the iomem-facing SD peripheral logic and the SPI byte engine, and owns chip select for the whole transaction.

## Interface
Parameters:
- R1_TRIES, 8: maximum poll bytes for the R1 response after the command.
- TOKEN_TIMEOUT, 4096: maximum poll bytes for the data start token 0xFE.
- BLOCK_ADDR, 1: 1 = command argument is the LBA (SDHC); 0 = argument is LBA<<9 (byte address, SDSC).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  read request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_lba  in  32  block number, sampled at accept.
- xfer_start  out  1  one-cycle pulse that starts one SPI byte exchange.
- xfer_tx  out  8  byte to send; valid with xfer_start.
- xfer_done  in  1  one-cycle pulse when the exchange completes.
- xfer_rx  in  8  received byte; valid with xfer_done.
- cs_n  out  1  SD chip select, active low.
- rd_valid  out  1  one-cycle pulse per data byte; no backpressure.
- rd_data  out  8  data byte.
- rd_index  out  9  byte offset 0..511.
- done  out  1  one-cycle pulse at end of transaction.
- error  out  1  qualifies done; high means the transaction failed.
- err_code  out  3  0 = ok, 1 = R1 timeout, 2 = R1 nonzero, 3 = token timeout, 4 = data error token, 5 = CRC mismatch.

## Operation
- States and transitions:
  - IDLE: on accept, go to CMD.
  - CMD: 6 bytes, then R1.
  - R1: poll with 0xFF until a byte with bit7 = 0. If the byte is 0x00, go to TOKEN; if nonzero, fail with code 2. After R1_TRIES bytes without a response, fail with code 1.
  - TOKEN: poll with 0xFF. 0xFE goes to DATA. A byte matching 0000xxxx fails with code 4. 0xFF continues polling, up to TOKEN_TIMEOUT bytes; then fail with code 3. Any other byte is treated as 0xFF.
  - DATA: 512 exchanges with tx 0xFF.
  - CRC: 2 exchanges with tx 0xFF.
  - TAIL: 1 exchange with tx 0xFF and cs_n = 1.
  - FIN: pulse done, then go to IDLE.
- Failure path: any failure skips directly to TAIL, then FIN with error = 1. err_code is latched and holds until the next accept.
- Command bytes: 0x51, then the argument MSB first, then 0xFF as the CRC byte (CRC is ignored in SPI mode).
  - With BLOCK_ADDR = 0, the argument is {req_lba[22:0], 9'b0}.
- cs_n is 0 from the cycle after accept through the end of CRC. It is 1 in IDLE, TAIL and FIN.
- Exactly one exchange is outstanding at a time. xfer_start is never asserted between a start and its matching xfer_done.
- Poll counters and the data counter are 13-bit and 10-bit saturating counters, cleared on state entry.

## Timing
- Reset values:
  - req_ready = 1, cs_n = 1.
  - xfer_start = 0, xfer_tx = 0xFF.
  - rd_valid = 0, rd_data = 0, rd_index = 0.
  - done = 0, error = 0, err_code = 0.
  - FSM in IDLE.
- First xfer_start is issued 1 cycle after accept.
- The next xfer_start is issued the cycle after xfer_done, so there is a 1-cycle gap per byte.
- rd_valid/rd_data/rd_index are registered outputs asserted the cycle after the xfer_done for the corresponding data byte.
- done is asserted the cycle after TAIL's xfer_done.
- req_ready returns high the cycle after done.
- req_valid while busy is ignored and does not queue.
- Reset mid-transaction:
  - Next cycle is IDLE with cs_n = 1 and no xfer_start.
  - A late xfer_done arriving in IDLE is ignored.
- An xfer_done pulse that arrives with no exchange outstanding is ignored in every state.

## Configuration
- SD_BLOCK_READER_CRC_CHECK_EN defined:
  - A CRC16-CCITT (poly 0x1021, init 0x0000) is accumulated over the 512 data bytes.
  - It is compared with the two CRC bytes, MSB first. A mismatch gives error = 1 with code 5.
  - Data bytes are still streamed in either case.
- Undefined: CRC bytes are discarded and code 5 is never produced.

## Test plan
- Nominal read: LBA 0x00000010, BLOCK_ADDR = 1; card model answers R1 0x00 on the 2nd poll, 0xFE after 3 polls, data byte i = i[7:0].
  - Command bytes: 51 00 00 00 10 FF.
  - 512 rd_valid pulses with rd_index 0..511.
  - done with error = 0; cs_n high from TAIL.
- Byte addressing: BLOCK_ADDR = 0, LBA 0x3 -> argument bytes 00 00 06 00.
- R1 failures:
  - Card always returns 0xFF -> after 8 polls, done with error = 1, err_code = 1.
  - R1 = 0x04 -> err_code = 2.
  - No rd_valid in either case.
- Token failures:
  - Token byte 0x08 -> err_code = 4.
  - 4096 bytes of 0xFF -> err_code = 3.
  - TAIL exchange occurs with cs_n = 1 in both cases.
- CRC check with macro defined:
  - Correct CRC over an all-0x00 block (0x0000) -> ok.
  - Flipped CRC LSB -> err_code = 5 after all 512 rd_valid pulses.
- Reset at data byte 100 -> next cycle cs_n = 1, req_ready = 1. A stray xfer_done is ignored, and a new request completes normally.
